// File: rtl/module_register_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// module_register_write_arbiter_if : requester/register-side bundle for the arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface module_register_write_arbiter_if #(
  parameter int ANCHO = 8,
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*ANCHO-1:0] data_in;
  logic [N_REQ-1:0]       ack;
  logic                   reg_we;
  logic [ANCHO-1:0]       reg_data;
  logic [IDW-1:0]         grant_id;
  logic                   busy;
  logic [CNT_W-1:0]       write_count;

  modport master (
    output req, data_in,
    input  ack, reg_we, reg_data, grant_id, busy, write_count
  );

  modport slave (
    input  req, data_in,
    output ack, reg_we, reg_data, grant_id, busy, write_count
  );
endinterface

`default_nettype wire

// File: rtl/module_register_write_arbiter.sv
// ----------------------------------------------------------------------------
// module_register_write_arbiter : round-robin arbiter owning the shared PIPO write port
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module module_register_write_arbiter #(
  parameter int ANCHO = 8,
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  wire logic                        clk,
  input  wire logic                        rst,
  module_register_write_arbiter_if.slave   bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_grant;
  logic [N_REQ-1:0]   r_ack;
  logic               r_we;
  logic [ANCHO-1:0]   r_reg_data;
  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_found;
  logic [IDW-1:0]     w_winner;
  logic [IDW-1:0]     w_idx;
  logic [IDW-1:0]     w_ptr_next;

  // First set request at or after the pointer, wrapping around.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_ptr_next = (r_grant == IDW'(N_REQ - 1)) ? '0 : r_grant + IDW'(1);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next_state = S_WRITE;
      S_WRITE: w_next_state = S_ACK;
      S_ACK:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_we       <= 1'b0;
      r_reg_data <= '0;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_reg_data <= bus.data_in[int'(w_winner)*ANCHO +: ANCHO];
            r_grant    <= w_winner;
            r_we       <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        // Outputs are registered one state ahead so they line up with the state.
        S_WRITE: begin
          r_we  <= 1'b0;
          r_ack <= N_REQ'(1) << r_grant;
          r_cnt <= r_cnt + CNT_W'(1);
          r_ptr <= w_ptr_next;
        end
        S_ACK: begin
          r_ack  <= '0;
          r_busy <= 1'b0;
        end
        default: begin
          r_ack  <= '0;
          r_we   <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack         = r_ack;
  assign bus.reg_we      = r_we;
  assign bus.reg_data    = r_reg_data;
  assign bus.grant_id    = r_grant;
  assign bus.busy        = r_busy;
  assign bus.write_count = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_module_register_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_module_register_write_arbiter : scoreboard bench for the round-robin write arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_module_register_write_arbiter;
  localparam int ANCHO = 8;
  localparam int N_REQ = 4;

  logic clk;
  logic rst;

  module_register_write_arbiter_if #(.ANCHO(ANCHO), .N_REQ(N_REQ), .CNT_W(16)) bus ();
  module_register_write_arbiter_if #(.ANCHO(ANCHO), .N_REQ(N_REQ), .CNT_W(4))  bus_w ();

  module_register_write_arbiter #(.ANCHO(ANCHO), .N_REQ(N_REQ), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Narrow-counter copy sees identical stimulus to exercise the wrap.
  module_register_write_arbiter #(.ANCHO(ANCHO), .N_REQ(N_REQ), .CNT_W(4)) u_dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w.slave)
  );

  assign bus_w.req     = bus.req;
  assign bus_w.data_in = bus.data_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_ptr = 0;
  int   m_cnt = 0;
  int   cyc = 0;
  int   last_we_cyc = -100;
  int   we_gap = 0;
  bit   ack_pending = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      chk("ack_not_with_we", {31'd0, bus.reg_we && (bus.ack != 0)}, 32'd0);
      if (bus.reg_we) begin
        chk("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          chk("reg_data", {24'd0, bus.reg_data}, {24'd0, cur.data});
          chk("grant_id", {30'd0, bus.grant_id}, cur.id);
          chk("busy_write", {31'd0, bus.busy}, 32'd1);
          ack_pending = 1'b1;
        end
        we_gap      = cyc - last_we_cyc;
        last_we_cyc = cyc;
      end
      if (bus.ack != 0) begin
        chk("ack_expected", {31'd0, ack_pending}, 32'd1);
        chk("ack_onehot", {28'd0, bus.ack}, 32'd1 << cur.id);
        chk("write_count", {16'd0, bus.write_count}, cur.cnt & 32'hFFFF);
        chk("write_count_w", {28'd0, bus_w.write_count}, cur.cnt & 32'hF);
        chk("ack_w", {28'd0, bus_w.ack}, {28'd0, bus.ack});
        ack_pending = 1'b0;
      end
    end
  end

  task automatic transact(input logic [3:0] r, input logic [31:0] d, input bit corrupt);
    exp_t e;
    bit   got;
    @(negedge clk);
    bus.req     = r;
    bus.data_in = d;
    e.id   = rr_pick(r, m_ptr);
    e.data = d[e.id*8 +: 8];
    m_cnt++;
    e.cnt  = m_cnt;
    m_ptr  = (e.id + 1) % 4;
    sb.push_back(e);
    @(posedge clk);
    if (corrupt) begin
      @(negedge clk);
      bus.data_in = 32'hFFFF_FFFF;
      bus.req     = 4'b0000;
    end
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.ack != 0) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_ack"}, {28'd0, bus.ack}, 32'd0);
    chk({tag, "_we"}, {31'd0, bus.reg_we}, 32'd0);
    chk({tag, "_data"}, {24'd0, bus.reg_data}, 32'd0);
    chk({tag, "_gid"}, {30'd0, bus.grant_id}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, bus.write_count}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_cleared("rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.req     = 4'($urandom_range(0, 15));
      bus.data_in = $urandom;
      chk("rst_hold_ack", {28'd0, bus.ack}, 32'd0);
      chk("rst_hold_we", {31'd0, bus.reg_we}, 32'd0);
    end
    @(negedge clk);
    bus.req     = '0;
    rst         = 1'b0;
    sb.delete();
    ack_pending = 1'b0;
    m_ptr       = 0;
    m_cnt       = 0;
    @(posedge clk);
    #1;
    check_cleared("post_rst");
  endtask

  initial begin
    rst         = 1'b1;
    bus.req     = '0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // Idle with no requests.
    repeat (5) @(posedge clk);
    #1;
    chk("idle_we", {31'd0, bus.reg_we}, 32'd0);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Single request on lane 2.
    transact(4'b0100, 32'h00A5_0000, 1'b0);
    @(negedge clk);
    bus.req = '0;
    do_reset();

    // All four requesting continuously: 0,1,2,3,0,...
    for (int i = 0; i < 8; i++) begin
      transact(4'b1111, 32'h4433_2211 + i, 1'b0);
      if (i > 0) chk("we_spacing", we_gap, 32'd3);
    end
    chk("cnt_after_8", {16'd0, bus.write_count}, 32'd8);
    @(negedge clk);
    bus.req = '0;
    repeat (3) @(posedge clk);

    // Data and req change while WRITE is in flight.
    transact(4'b0010, 32'h0000_3C00, 1'b1);
    @(negedge clk);
    bus.req = '0;
    repeat (2) @(posedge clk);

    // Abort during WRITE.
    @(negedge clk);
    bus.req     = 4'b0001;
    bus.data_in = 32'h0000_0077;
    @(posedge clk);
    #1;
    chk("abort_we_before", {31'd0, bus.reg_we}, 32'd1);
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_ack", {28'd0, bus.ack}, 32'd0);
    transact(4'b1000, 32'h5A00_0000, 1'b0);
    chk("abort_next_gid", {30'd0, bus.grant_id}, 32'd3);
    @(negedge clk);
    bus.req = '0;
    do_reset();

    // Seventeen writes: narrow counter goes 15 -> 0 -> 1.
    for (int i = 0; i < 17; i++) begin
      transact(4'b0001, 32'h0000_0040 + i, 1'b0);
      if (i == 14) chk("wrap_15", {28'd0, bus_w.write_count}, 32'd15);
      if (i == 15) chk("wrap_0", {28'd0, bus_w.write_count}, 32'd0);
      if (i == 16) chk("wrap_1", {28'd0, bus_w.write_count}, 32'd1);
    end
    @(negedge clk);
    bus.req = '0;
    repeat (4) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/module_register_write_arbiter.md
Name: module_register_write_arbiter

Overview:
Round-robin write arbiter that shares one parallel-in/parallel-out register between N_REQ requesters. It captures the winning requester's data and drives the register's write-enable and data for exactly one cycle. It then acknowledges the winner. It sits directly in front of the shared PIPO register and is the only agent allowed to drive that register's we/data_in.

Parameters:
ANCHO, 8, data width of the shared register and of each requester's data.
N_REQ, 4, number of requesters (2..16).
IDW, $clog2(N_REQ), derived width of the grant index (localparam, not overridable).
CNT_W, 16, width of the completed-write counter.

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  reset, asynchronous, active-high; clears all state immediately.
req  input  N_REQ  per-requester write request, level; bit i belongs to requester i.
data_in  input  N_REQ*ANCHO  flattened request data; requester i uses bits [i*ANCHO +: ANCHO].
ack  output  N_REQ  one-hot, one-cycle acknowledge to the served requester.
reg_we  output  1  write enable to the shared register.
reg_data  output  ANCHO  data to the shared register.
grant_id  output  IDW  index of the requester currently or last served.
busy  output  1  high while a transaction is in progress (not IDLE).
write_count  output  CNT_W  number of completed writes, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst=1): state=IDLE; ack=0, reg_we=0, reg_data=0, grant_id=0, busy=0, write_count=0, rr pointer=0. All outputs are registered; no glitches on deassertion.
- FSM, 3 states:
  - IDLE: if any req bit set, select a winner by round-robin; capture its data into reg_data; grant_id=winner; go to WRITE. Otherwise stay in IDLE.
  - WRITE, one cycle: reg_we=1, busy=1; go to ACK.
  - ACK, one cycle: ack[grant_id]=1, reg_we=0, busy=1; write_count+1; rr pointer=(grant_id+1) mod N_REQ; go to IDLE.
- Round-robin: search req starting at rr pointer, ascending with wrap; the first set bit wins. After reset requester 0 has top priority. A requester just served has lowest priority at the next arbitration.
- Latency: req sampled in IDLE at edge t; reg_we high during cycle t+1; ack high during cycle t+2; earliest next arbitration at edge t+3. Maximum throughput is one write per 3 cycles.
- Data is captured at the IDLE->WRITE edge. Later changes to data_in or req during WRITE/ACK are ignored for that transaction.
- Requester withdraws req during WRITE/ACK: the write still completes and the ack is still pulsed.
- Requesters must drop req in the cycle after ack. A req still high when IDLE is re-entered counts as a new request.
- reg_data holds its last value when idle. grant_id holds the last winner.
- Simultaneous requests: exactly one winner per transaction; ack is never multi-hot.
- Reset mid-transaction (WRITE or ACK): the transaction is aborted with no ack pulse. write_count and the pointer clear to 0. reg_we falls to 0 immediately (asynchronously).
- write_count wraps from 2^CNT_W-1 to 0 with no flag.
- req=0 always: the block stays in IDLE, reg_we=0, outputs stable.

Test Plan:
- Reset: apply rst=1 mid-stream with random req/data. Required: all outputs 0 within the same cycle; after release, IDLE, busy=0.
- Single request: ANCHO=8, req=4'b0100, data_in lane2=8'hA5. Required: reg_we=1 with reg_data=8'hA5 one cycle after sampling; ack=4'b0100 the next cycle; grant_id=2; write_count=1.
- Round-robin fairness: req=4'b1111 held, re-asserted after each ack. Required: grant order 0,1,2,3,0,...; each ack is one-hot; one reg_we pulse per 3 cycles; write_count=8 after 8 grants.
- Data capture: grant requester 1 with data 8'h3C, then change lane1 to 8'hFF during WRITE. Required: reg_data stays 8'h3C for that write.
- Abort: assert rst during WRITE. Required: reg_we drops immediately; no ack is issued; write_count=0. The next request from requester 3 alone gets grant_id=3.
- Counter wrap: set CNT_W=4 and perform 17 writes. Required: write_count goes 15 -> 0 -> 1.
